// File: rtl/sample_stream_pkg.sv
// Package: sample_stream_pkg
// Purpose: shared types and helpers for the sample stream FIFO.
//   stat_t   - 32-bit statistics counter type
//   STAT_MAX - saturation value for stat_t counters
//   sat_inc  - saturating increment of a stat_t value
package sample_stream_pkg;

  localparam int unsigned STAT_W = 32;

  typedef logic [STAT_W-1:0] stat_t;

  localparam stat_t STAT_MAX = 32'hFFFF_FFFF;

  // Increment that sticks at STAT_MAX instead of wrapping to zero.
  function automatic stat_t sat_inc(input stat_t value);
    return (value == STAT_MAX) ? value : value + STAT_W'(1);
  endfunction

endpackage : sample_stream_pkg

// File: rtl/sample_stream_if.sv
// Interface: sample_stream_if
// Purpose: ready/valid stream bundle carrying DATA_WIDTH-bit payloads.
//   valid - producer has data
//   ready - consumer can accept
//   data  - payload
// Modports:
//   master - drives valid/data, observes ready (producer side)
//   slave  - observes valid/data, drives ready (consumer side)
interface sample_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface : sample_stream_if

// File: rtl/sample_stream_ram.sv
// Module: sample_stream_ram
// Purpose: DEPTH x DATA_WIDTH register array backing the stream FIFO.
//   One synchronous write port, one asynchronous read port.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from the array)
module sample_stream_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; validity is tracked by the FIFO pointers and level.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : sample_stream_ram

// File: rtl/sample_stream_fifo.sv
// Module: sample_stream_fifo
// Purpose: DEPTH-entry first-word-fall-through ready/valid FIFO between a
//   stream driver and a stream monitor, with a combinational data mirror and
//   push-strobe output.
// Ports:
//   clk                  - clock, all logic on posedge
//   reset                - synchronous, active-high
//   stream_in            - input stream (slave modport): valid/data in, ready out
//   stream_out           - output stream (master modport): valid/data out, ready in
//   stream_out_data_comb - combinational copy of stream_in.data
//   and_output           - stream_in.valid & stream_in.ready (push strobe)
//   level                - current occupancy, 0..DEPTH
// Optional (macro SAMPLE_STREAM_STATS_EN):
//   stat_in_count        - saturating push count
//   stat_out_count       - saturating pop count
//   stat_stall_count     - saturating count of cycles with valid & !ready on input
module sample_stream_fifo
  import sample_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_stream_if.slave        stream_in,
  sample_stream_if.master       stream_out,
  output logic [DATA_WIDTH-1:0] stream_out_data_comb,
  output logic                  and_output,
  output logic [CNT_W-1:0]      level
`ifdef SAMPLE_STREAM_STATS_EN
  ,
  output stat_t                 stat_in_count,
  output stat_t                 stat_out_count,
  output stat_t                 stat_stall_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      level_q;
  logic [CNT_W-1:0]      level_d;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;

  // Handshakes: ready/valid are registered, so neither depends on the other side.
  assign push = stream_in.valid & in_ready_q;
  assign pop  = out_valid_q & stream_out.ready;

  // Next occupancy: simultaneous push and pop leave the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + CNT_W'(1);
      2'b01:   level_d = level_q - CNT_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers, level and registered handshake flags; ready/valid look ahead at level_d.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q     <= level_d;
      in_ready_q  <= (level_d != CNT_W'(DEPTH));
      out_valid_q <= (level_d != CNT_W'(0));
    end
  end

  sample_stream_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr_q),
    .wdata (stream_in.data),
    .raddr (rd_ptr_q),
    .rdata (head_data)
  );

  assign stream_in.ready  = in_ready_q;
  assign stream_out.valid = out_valid_q;
  // Head entry when non-empty; zero when empty so stale words are never shown.
  assign stream_out.data  = out_valid_q ? head_data : '0;
  assign level            = level_q;

  // Pure combinational taps, independent of reset.
  assign stream_out_data_comb = stream_in.data;
  assign and_output           = stream_in.valid & stream_in.ready;

`ifdef SAMPLE_STREAM_STATS_EN
  stat_t in_count_q;
  stat_t out_count_q;
  stat_t stall_count_q;

  // Saturating traffic and back-pressure counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_count_q    <= '0;
      out_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (push) begin
        in_count_q <= sat_inc(in_count_q);
      end
      if (pop) begin
        out_count_q <= sat_inc(out_count_q);
      end
      if (stream_in.valid && !in_ready_q) begin
        stall_count_q <= sat_inc(stall_count_q);
      end
    end
  end

  assign stat_in_count    = in_count_q;
  assign stat_out_count   = out_count_q;
  assign stat_stall_count = stall_count_q;
`endif

endmodule : sample_stream_fifo

// File: tb/tb_sample_stream_fifo.sv
// Testbench: tb_sample_stream_fifo
// Purpose: directed self-checking bench for sample_stream_fifo (DATA_WIDTH=8,
//   DEPTH=4). Stats checks are compiled when SAMPLE_STREAM_STATS_EN is defined.
module tb_sample_stream_fifo;
  import sample_stream_pkg::*;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);

  logic                  clk;
  logic                  reset;
  logic [DATA_WIDTH-1:0] data_comb;
  logic                  and_out;
  logic [CNT_W-1:0]      level;

  int errors = 0;
  int checks = 0;

  sample_stream_if #(.DATA_WIDTH(DATA_WIDTH)) in_if ();
  sample_stream_if #(.DATA_WIDTH(DATA_WIDTH)) out_if ();

`ifdef SAMPLE_STREAM_STATS_EN
  stat_t stat_in;
  stat_t stat_out;
  stat_t stat_stall;
`endif

  sample_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .stream_in            (in_if.slave),
    .stream_out           (out_if.master),
    .stream_out_data_comb (data_comb),
    .and_output           (and_out),
    .level                (level)
`ifdef SAMPLE_STREAM_STATS_EN
    ,
    .stat_in_count        (stat_in),
    .stat_out_count       (stat_out),
    .stat_stall_count     (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_if.valid = 1'b1;
    in_if.data  = d;
    tick();
    in_if.valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    in_if.valid  = 1'b0;
    in_if.data   = 8'h3C;
    out_if.ready = 1'b0;

    // 1. Reset held two cycles; combinational taps ignore reset.
    tick();
    tick();
    check("rst_in_ready", 64'(in_if.ready), 64'd0);
    check("rst_comb_mirror", 64'(data_comb), 64'h3C);
    in_if.valid = 1'b1;
    #1;
    check("rst_and_output", 64'(and_out), 64'd0);
    in_if.valid = 1'b0;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_data", 64'(out_if.data), 64'd0);
    tick();
    check("post_rst_in_ready", 64'(in_if.ready), 64'd1);
    check("post_rst_out_valid", 64'(out_if.valid), 64'd0);

    // 2. Single push, then hold under back-pressure.
    in_if.valid = 1'b1;
    in_if.data  = 8'hA5;
    #1;
    check("push_strobe", 64'(and_out), 64'd1);
    check("comb_mirror_a5", 64'(data_comb), 64'hA5);
    tick();
    in_if.valid = 1'b0;
    check("fwft_valid", 64'(out_if.valid), 64'd1);
    check("fwft_data", 64'(out_if.data), 64'hA5);
    check("fwft_level", 64'(level), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_data", 64'(out_if.data), 64'hA5);
      check("stall_hold_valid", 64'(out_if.valid), 64'd1);
    end
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
    check("drain_level", 64'(level), 64'd0);
    check("drain_valid", 64'(out_if.valid), 64'd0);
    check("empty_data_zero", 64'(out_if.data), 64'd0);

    // 3. Fill to full, reject an extra word, drain in order.
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    check("full_level", 64'(level), 64'd4);
    check("full_in_ready", 64'(in_if.ready), 64'd0);
    in_if.valid = 1'b1;
    in_if.data  = 8'h05;
    #1;
    check("full_no_strobe", 64'(and_out), 64'd0);
    tick();
    in_if.valid = 1'b0;
    check("full_reject_level", 64'(level), 64'd4);
    out_if.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("order_data", 64'(out_if.data), 64'(i));
      tick();
    end
    out_if.ready = 1'b0;
    check("order_empty_level", 64'(level), 64'd0);
    check("order_empty_valid", 64'(out_if.valid), 64'd0);

    // 4. Full FIFO with push and pop offered together.
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    in_if.valid  = 1'b1;
    in_if.data   = 8'h05;
    out_if.ready = 1'b1;
    #1;
    check("fullpop_in_ready", 64'(in_if.ready), 64'd0);
    check("fullpop_head", 64'(out_if.data), 64'h01);
    tick();
    check("fullpop_level", 64'(level), 64'd3);
    check("fullpop_ready_back", 64'(in_if.ready), 64'd1);
    check("fullpop_next_head", 64'(out_if.data), 64'h02);
    tick();
    in_if.valid = 1'b0;
    check("pushpop_level", 64'(level), 64'd3);
    for (int i = 3; i <= 5; i++) begin
      check("fullpop_order", 64'(out_if.data), 64'(i));
      tick();
    end
    out_if.ready = 1'b0;
    check("fullpop_empty", 64'(level), 64'd0);

    // 5. Ten words streamed with the consumer always ready; pointers wrap.
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 8'h10;
    tick();
    for (int i = 1; i < 10; i++) begin
      in_if.data = 8'(8'h10 + i);
      check("stream_data", 64'(out_if.data), 64'(8'h10 + i - 1));
      check("stream_level", 64'(level), 64'd1);
      tick();
    end
    in_if.valid = 1'b0;
    check("stream_last", 64'(out_if.data), 64'h19);
    tick();
    out_if.ready = 1'b0;
    check("stream_empty", 64'(level), 64'd0);

    // 6. Reset with three words loaded flushes them.
    for (int i = 1; i <= 3; i++) push_word(8'(8'h30 + i));
    check("preflush_level", 64'(level), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_valid", 64'(out_if.valid), 64'd0);
    check("flush_data", 64'(out_if.data), 64'd0);
    check("flush_in_ready", 64'(in_if.ready), 64'd0);
    tick();
    check("flush_ready_back", 64'(in_if.ready), 64'd1);
    push_word(8'h44);
    check("post_flush_head", 64'(out_if.data), 64'h44);
    check("post_flush_level", 64'(level), 64'd1);
    out_if.ready = 1'b1;
    tick();
    out_if.ready = 1'b0;
    check("post_flush_empty", 64'(out_if.valid), 64'd0);

`ifdef SAMPLE_STREAM_STATS_EN
    // Stats: fresh reset, fill, then six full-stall cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("stat_clear", 64'(stat_in), 64'd0);
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    in_if.valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    in_if.valid = 1'b0;
    check("stat_stall", 64'(stat_stall), 64'd6);
    check("stat_in", 64'(stat_in), 64'd4);
    check("stat_out", 64'(stat_out), 64'd0);
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_if.ready = 1'b0;
    check("stat_out_drain", 64'(stat_out), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sample_stream_fifo
